// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_PE PE controllers.
// Optional BUSY-state abort timer: define PE_MEM_ARB_TIMEOUT_EN.
module pe_mem_arbiter #(
   parameter int unsigned NUM_PE         = 4,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   localparam int unsigned ID_W          = $clog2(NUM_PE)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_PE-1:0]        req_read,
   input  logic [NUM_PE-1:0]        req_write,
   input  logic [NUM_PE*ADDR_W-1:0] req_addr,
   input  logic [NUM_PE*DATA_W-1:0] req_wdata,
   output logic [NUM_PE-1:0]        req_ack,
   output logic [DATA_W-1:0]        req_rdata,
   output logic                     req_err,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_address,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ack,
   output logic                     busy,
   output logic [ID_W-1:0]          grant_id
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (NUM_PE < 2 || NUM_PE > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("pe_mem_arbiter: parameter out of range");
   end

   logic [1:0]        state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   rr_eff;
   logic [NUM_PE-1:0] active;
   logic              any_active;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   pick_next;
   int unsigned       scan_idx;

   assign active     = req_read | req_write;
   assign any_active = |active;

   // Out-of-range pointer values (non-power-of-two NUM_PE) restart the scan at slot 0.
   assign rr_eff = (32'(rr_ptr) >= NUM_PE) ? '0 : rr_ptr;

   always_comb begin
      logic found;
      found    = 1'b0;
      pick     = '0;
      scan_idx = 0;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
         scan_idx = (32'(rr_eff) + k) % NUM_PE;
         if (!found && active[scan_idx]) begin
            found = 1'b1;
            pick  = scan_idx[ID_W-1:0];
         end
      end
   end

   assign pick_next = (32'(pick) == NUM_PE - 1) ? '0 : pick + 1'b1;

`ifdef PE_MEM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] to_cnt;
   logic             to_hit;

   assign to_hit = (32'(to_cnt) == TIMEOUT_CYCLES - 1);
`else
   assign req_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         req_ack     <= '0;
         req_rdata   <= '0;
         busy        <= 1'b0;
`ifdef PE_MEM_ARB_TIMEOUT_EN
         req_err     <= 1'b0;
         to_cnt      <= '0;
`endif
      end else begin
         req_ack <= '0;
         case (state)
            S_IDLE: begin
               if (any_active) begin
                  state       <= S_BUSY;
                  grant_id    <= pick;
                  rr_ptr      <= pick_next;
                  mem_address <= req_addr[pick*ADDR_W +: ADDR_W];
                  mem_wdata   <= req_wdata[pick*DATA_W +: DATA_W];
                  // Write takes priority when a slot raises both strobes.
                  mem_write   <= req_write[pick];
                  mem_read    <= ~req_write[pick];
                  busy        <= 1'b1;
`ifdef PE_MEM_ARB_TIMEOUT_EN
                  to_cnt      <= '0;
`endif
               end
            end

            S_BUSY: begin
               if (mem_ack) begin
                  state       <= S_DONE;
                  mem_read    <= 1'b0;
                  mem_write   <= 1'b0;
                  mem_address <= '0;
                  mem_wdata   <= '0;
                  req_rdata   <= mem_read ? mem_rdata : '0;
                  req_ack     <= NUM_PE'(1) << grant_id;
`ifdef PE_MEM_ARB_TIMEOUT_EN
                  req_err     <= 1'b0;
               end else if (to_hit) begin
                  state       <= S_DONE;
                  mem_read    <= 1'b0;
                  mem_write   <= 1'b0;
                  mem_address <= '0;
                  mem_wdata   <= '0;
                  req_rdata   <= '0;
                  req_ack     <= NUM_PE'(1) << grant_id;
                  req_err     <= 1'b1;
               end else begin
                  to_cnt      <= to_cnt + 1'b1;
`endif
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
`ifdef PE_MEM_ARB_TIMEOUT_EN
               req_err <= 1'b0;
`endif
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
